// File: rtl/fetch_pc_redirect_pkg.sv
// Processor-wide fetch definitions: PC width, instruction size and the
// prediction record kept for every fetched instruction until EX resolves it.
package fetch_pc_redirect_pkg;

    localparam int              PC_W        = 32;
    localparam logic [PC_W-1:0] INSTR_BYTES = 32'd4;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] pred_next;
    } pred_entry_t;

    // Fall-through address; wraps modulo 2^32, low bits carried through.
    function automatic logic [PC_W-1:0] seq_pc(input logic [PC_W-1:0] pc);
        return pc + INSTR_BYTES;
    endfunction

endpackage

// File: rtl/fetch_pc_redirect_if.sv
// Fetch-stage bus: branch target cache lookup, EX resolution and fetch status.
// The pipeline side is the master, the fetch PC unit is the slave.
interface fetch_pc_redirect_if
    import fetch_pc_redirect_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic              iStall;
    logic              iCacheHit;
    logic [PC_W-1:0]   iCacheAddress;
    logic              iResValid;
    logic              iResTaken;
    logic [PC_W-1:0]   iResTarget;
    logic [PC_W-1:0]   oPC;
    logic              oFetchValid;
    logic              oFlush;
    logic              oQFull;
    logic [CNT_W-1:0]  oHitCnt;
    logic [CNT_W-1:0]  oMissCnt;

    modport master (
        output iStall, iCacheHit, iCacheAddress, iResValid, iResTaken, iResTarget,
        input  oPC, oFetchValid, oFlush, oQFull, oHitCnt, oMissCnt
    );

    modport slave (
        input  iStall, iCacheHit, iCacheAddress, iResValid, iResTaken, iResTarget,
        output oPC, oFetchValid, oFlush, oQFull, oHitCnt, oMissCnt
    );

endinterface

// File: rtl/fetch_pc_redirect_pred_fifo.sv
// Circular buffer of in-flight predictions, oldest at the head.
// Supports simultaneous push/pop and a synchronous clear used on mispredict.
module fetch_pc_redirect_pred_fifo
    import fetch_pc_redirect_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clr,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  pred_entry_t              i_wdata,
    output pred_entry_t              o_head,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PTR_W = $clog2(DEPTH);

    pred_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W:0]     r_count;

    // NOTE: storage has no reset; only pointers and count define validity,
    // so clearing them is enough and the array maps onto plain RAM/flops.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_pc_redirect.sv
// Fetch PC register with BTC-driven next-PC selection, in-flight prediction
// tracking, mispredict redirect/flush and saturating hit/miss statistics.
module fetch_pc_redirect
    import fetch_pc_redirect_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'd0,
    parameter int              QDEPTH   = 4,
    parameter int              CNT_W    = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    fetch_pc_redirect_if.slave    bus
);
    localparam int             CW       = $clog2(QDEPTH) + 1;
    localparam logic [CW-1:0]  QDEPTH_C = CW'(QDEPTH);

    logic [PC_W-1:0]   r_pc;
    logic              r_flush;
    logic [CNT_W-1:0]  r_hit_cnt;
    logic [CNT_W-1:0]  r_miss_cnt;

    pred_entry_t       w_head;
    pred_entry_t       w_entry;
    logic [CW-1:0]     w_count;
    logic              w_pop;
    logic              w_push;
    logic              w_mispredict;
    logic [PC_W-1:0]   w_pred_next;
    logic [PC_W-1:0]   w_actual_next;
    logic [PC_W-1:0]   w_pc_next;

    fetch_pc_redirect_pred_fifo #(.DEPTH(QDEPTH)) u_pred_fifo (
        .i_clk   (Clk),
        .i_rst   (Reset),
        .i_clr   (w_mispredict),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_entry),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // Reset gates push/pop so a resolve arriving during reset is dropped.
    always_comb begin
        w_pred_next   = bus.iCacheHit ? bus.iCacheAddress : seq_pc(r_pc);
        w_pop         = ~Reset & bus.iResValid & (w_count != '0);
        w_actual_next = bus.iResTaken ? bus.iResTarget : seq_pc(w_head.pc);
        w_mispredict  = w_pop & (w_actual_next != w_head.pred_next);
        w_push        = ~Reset & ~bus.iStall & ~w_mispredict
                        & ((w_count < QDEPTH_C) | w_pop);
        w_entry       = '{pc: r_pc, pred_next: w_pred_next};
        w_pc_next     = r_pc;
        if (w_mispredict) begin
            w_pc_next = w_actual_next;
        end else if (w_push) begin
            w_pc_next = w_pred_next;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pc       <= RESET_PC;
            r_flush    <= 1'b0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_pc    <= w_pc_next;
            r_flush <= w_mispredict;
            if (w_push && bus.iCacheHit && (r_hit_cnt != '1)) begin
                r_hit_cnt <= r_hit_cnt + 1'b1;
            end
            if (w_mispredict && (r_miss_cnt != '1)) begin
                r_miss_cnt <= r_miss_cnt + 1'b1;
            end
        end
    end

    assign bus.oPC         = r_pc;
    assign bus.oFetchValid = w_push;
    assign bus.oFlush      = r_flush;
    assign bus.oQFull      = (w_count == QDEPTH_C);
    assign bus.oHitCnt     = r_hit_cnt;
    assign bus.oMissCnt    = r_miss_cnt;

endmodule
